// File: rtl/dac_mix_sched.sv
// Three-channel sample mixer feeding a sigma-delta DAC, sequenced once per sample tick.
// Optional feature: define DAC_SOFT_MUTE_EN for a 1-LSB-per-period mute ramp instead of a hard mute.
module dac_mix_sched #(
    parameter int WIDTH = 8,
    parameter int DIV   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           s_valid,
    input  logic [3*WIDTH-1:0]   s_data,
    output logic [2:0]           s_ready,
    input  logic                 mute,
    output logic [WIDTH-1:0]     dac_value,
    output logic                 sample_tick,
    output logic [2:0]           underrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ACC0 = 3'd1;
    localparam logic [2:0] ACC1 = 3'd2;
    localparam logic [2:0] ACC2 = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;

    logic [CW-1:0]      div_cnt;
    logic [2:0]         state;
    logic [WIDTH+1:0]   acc;
    logic [WIDTH-1:0]   slot     [3];
    logic [WIDTH-1:0]   last_val [3];
    logic [2:0]         full;

    logic [1:0]         sel;
    logic               acc_phase;
    logic               cur_full;
    logic [WIDTH-1:0]   cur_slot;
    logic [WIDTH-1:0]   cur_last;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH+1:0]   adder_a;
    logic [WIDTH+1:0]   sum;
    logic [WIDTH-1:0]   mix_sat;
    logic [WIDTH-1:0]   muted_value;

    assign sample_tick = (div_cnt == DIV_LAST);
    assign s_ready     = ~full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (sample_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    always_comb begin
        sel       = 2'd0;
        acc_phase = 1'b0;
        case (state)
            ACC0: begin sel = 2'd0; acc_phase = 1'b1; end
            ACC1: begin sel = 2'd1; acc_phase = 1'b1; end
            ACC2: begin sel = 2'd2; acc_phase = 1'b1; end
            default: begin sel = 2'd0; acc_phase = 1'b0; end
        endcase
    end

    always_comb begin
        cur_full = full[0];
        cur_slot = slot[0];
        cur_last = last_val[0];
        case (sel)
            2'd1: begin cur_full = full[1]; cur_slot = slot[1]; cur_last = last_val[1]; end
            2'd2: begin cur_full = full[2]; cur_slot = slot[2]; cur_last = last_val[2]; end
            default: begin cur_full = full[0]; cur_slot = slot[0]; cur_last = last_val[0]; end
        endcase
    end

    // One shared adder: ACC0 starts from zero, later phases add onto the accumulator.
    assign operand = cur_full ? cur_slot : cur_last;
    assign adder_a = (state == ACC0) ? '0 : acc;
    assign sum     = adder_a + {2'b00, operand};
    assign mix_sat = (acc[WIDTH+1:WIDTH] != 2'b00) ? {WIDTH{1'b1}} : acc[WIDTH-1:0];

`ifdef DAC_SOFT_MUTE_EN
    assign muted_value = (dac_value == '0) ? '0 : dac_value - WIDTH'(1);
`else
    assign muted_value = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= sample_tick ? ACC0 : IDLE;
                ACC0:    state <= ACC1;
                ACC1:    state <= ACC2;
                ACC2:    state <= OUT;
                OUT:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            dac_value <= '0;
        end else begin
            if (acc_phase) begin
                acc <= sum;
            end
            if (state == OUT) begin
                dac_value <= mute ? muted_value : mix_sat;
            end
        end
    end

    // A slot is only consumed when full and only accepted when empty, so the two never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 3'b000;
            underrun <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                slot[i]     <= '0;
                last_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (acc_phase && (sel == 2'(i))) begin
                    if (full[i]) begin
                        full[i]     <= 1'b0;
                        last_val[i] <= slot[i];
                    end else begin
                        underrun[i] <= 1'b1;
                        if (s_valid[i]) begin
                            slot[i] <= s_data[i*WIDTH +: WIDTH];
                            full[i] <= 1'b1;
                        end
                    end
                end else if (s_valid[i] && !full[i]) begin
                    slot[i] <= s_data[i*WIDTH +: WIDTH];
                    full[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_mix_sched.sv
// Randomized scoreboard bench for dac_mix_sched; per-period mix model, monitor checks dac_value at T+5.
module tb_dac_mix_sched;

    localparam int WIDTH = 8;
    localparam int DIV   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [2:0]         s_valid = 3'b000;
    logic [3*WIDTH-1:0] s_data = '0;
    logic [2:0]         s_ready;
    logic               mute = 1'b0;
    logic [WIDTH-1:0]   dac_value;
    logic               sample_tick;
    logic [2:0]         underrun;

    dac_mix_sched #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mute       (mute),
        .dac_value  (dac_value),
        .sample_tick(sample_tick),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         dac;
        logic [2:0] ur;
    } exp_t;

    typedef struct {
        logic [2:0] mask;
        int         d0;
        int         d1;
        int         d2;
        bit         m;
    } period_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    // Reference state: what each channel last delivered, sticky underruns, last DAC code.
    int         last_v[3];
    logic [2:0] ur_m = 3'b000;
    int         dac_m = 0;
    int         hold_left = 0;
    bit         holding = 1'b0;
    int         hold_d = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (!sample_tick && n < 4*DIV) begin
            @(negedge clk);
            n++;
        end
        check_output("tick_seen", int'(sample_tick), 1);
    endtask

    // Called at a negedge with all slots drained; sets up the samples and mute for the next period.
    task automatic apply_stimulus(input logic [2:0] mask, input int d0, input int d1, input int d2, input bit m);
        int         d[3];
        int         v[3];
        logic [2:0] supplied;
        bit         ch1_forced;
        bit         holding_next;
        int         total;
        exp_t       e;
        d = '{d0, d1, d2};
        check_output("ready_before_push", int'(s_ready), holding ? 5 : 7);
        supplied     = 3'b000;
        ch1_forced   = 1'b0;
        holding_next = 1'b0;
        s_valid      = 3'b000;
        for (int i = 0; i < 3; i++) v[i] = last_v[i];
        if (hold_left > 0) begin
            s_valid[1]      = 1'b1;
            s_data[15:8]    = 8'(hold_d);
            v[1]            = hold_d;
            supplied[1]     = 1'b1;
            ch1_forced      = 1'b1;
            holding_next    = 1'b1;
            hold_left--;
        end else if (holding) begin
            v[1]        = hold_d;
            supplied[1] = 1'b1;
            ch1_forced  = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (mask[i] && !(i == 1 && ch1_forced)) begin
                s_valid[i]          = 1'b1;
                s_data[i*8 +: 8]    = 8'(d[i]);
                v[i]                = d[i];
                supplied[i]         = 1'b1;
            end
        end
        mute  = m;
        ur_m  = ur_m | ~supplied;
        total = v[0] + v[1] + v[2];
        for (int i = 0; i < 3; i++) last_v[i] = v[i];
        if (m) begin
`ifdef DAC_SOFT_MUTE_EN
            dac_m = (dac_m > 0) ? dac_m - 1 : 0;
`else
            dac_m = 0;
`endif
        end else begin
            dac_m = (total > 255) ? 255 : total;
        end
        e.dac = dac_m;
        e.ur  = ur_m;
        exp_q.push_back(e);
        @(negedge clk);
        s_valid = holding_next ? 3'b010 : 3'b000;
        holding = holding_next;
    endtask

    // Waits out one period, checking the single-accept ready pattern while channel 1 is held valid.
    task automatic run_period(input period_t p);
        wait_tick();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (holding && k >= 2 && k <= 4)
                check_output("hold_ready1", int'(s_ready[1]), (k == 3) ? 1 : 0);
        end
        apply_stimulus(p.mask, p.d0, p.d1, p.d2, p.m);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sample_tick && mon_en) begin
                repeat (5) @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_empty: got output %0d, expected none", dac_value);
                end else begin
                    e = exp_q.pop_front();
                    check_output("dac_value", int'(dac_value), e.dac);
                    check_output("underrun", int'(underrun), int'(e.ur));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        period_t dir[9];
        period_t p;
        for (int i = 0; i < 3; i++) last_v[i] = 0;
        dir[0] = '{3'b111, 10, 20, 30, 1'b0};
        dir[1] = '{3'b111, 200, 100, 50, 1'b0};
        dir[2] = '{3'b111, 10, 20, 30, 1'b0};
        dir[3] = '{3'b001, 5, 0, 0, 1'b0};
        dir[4] = '{3'b111, 10, 20, 30, 1'b0};
        dir[5] = '{3'b111, 1, 2, 3, 1'b1};
        dir[6] = '{3'b111, 1, 2, 3, 1'b1};
        dir[7] = '{3'b111, 1, 2, 3, 1'b1};
        dir[8] = '{3'b000, 0, 0, 0, 1'b0};

        repeat (3) @(negedge clk);
        check_output("reset_dac", int'(dac_value), 0);
        check_output("reset_ready", int'(s_ready), 7);
        check_output("reset_underrun", int'(underrun), 0);
        check_output("reset_tick", int'(sample_tick), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        apply_stimulus(dir[0].mask, dir[0].d0, dir[0].d1, dir[0].d2, dir[0].m);
        for (int i = 1; i < 9; i++) run_period(dir[i]);

        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin
                hold_left = 4;
                hold_d    = int'($urandom_range(0, 255));
            end
            p.mask = 3'($urandom_range(0, 7));
            p.d0   = int'($urandom_range(0, 255));
            p.d1   = int'($urandom_range(0, 255));
            p.d2   = int'($urandom_range(0, 255));
            p.m    = ($urandom_range(0, 4) == 0);
            run_period(p);
        end

        wait_tick();
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        mute   = 1'b0;

        // Abandon a mix mid-sequence with reset; nothing partial may reach the DAC.
        s_valid = 3'b111;
        s_data  = {8'd30, 8'd20, 8'd10};
        @(negedge clk);
        s_valid = 3'b000;
        wait_tick();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midreset_dac", int'(dac_value), 0);
        check_output("midreset_ready", int'(s_ready), 7);
        check_output("midreset_underrun", int'(underrun), 0);
        check_output("midreset_tick", int'(sample_tick), 0);
        rst_n = 1'b1;
        wait_tick();
        repeat (5) @(negedge clk);
        check_output("post_reset_dac", int'(dac_value), 0);
        check_output("post_reset_underrun", int'(underrun), 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
